sequence_generator: RTL and testbench
=====================================

SEQUENCE_GENERATOR -- requirements
Module: sequence_generator

Interface
REQ-001 Parameter PAT_W, default 4: pattern width in bits, legal range 2..16.
REQ-002 Port clk, input, 1: system clock; all logic on its rising edge.
REQ-003 Port reset, input, 1: reset, synchronous, active-high.
REQ-004 Port start, input, 1: request to transmit; sampled only in IDLE.
REQ-005 Port abort, input, 1: cancel current transmission.
REQ-006 Port pattern, input, PAT_W: bit pattern to send (e.g. 4'b1011); captured when start is accepted.
REQ-007 Port repeat_cnt, input, 4: number of pattern repetitions (0..15); captured when start is accepted.
REQ-008 Port out, output, 1: serial data bit, MSB of pattern first.
REQ-009 Port valid, output, 1: out carries a pattern bit this cycle.
REQ-010 Port busy, output, 1: high in any state other than IDLE.
REQ-011 Port done, output, 1: single-cycle pulse on normal completion.

Function
REQ-012 The block SHALL have states IDLE, SEND, GAP, DONE; all outputs SHALL be registered.
REQ-013 In IDLE, start=1 at an edge SHALL latch pattern and repeat_cnt, and SHALL move to SEND with out=pattern[PAT_W-1] and valid=1 in the next cycle (1-cycle latency); if repeat_cnt=0, the block SHALL move to DONE instead, with valid never asserted.
REQ-014 SEND SHALL emit one bit per cycle, MSB to LSB, from the latched pattern; input changes after capture SHALL have no effect.
REQ-015 After the LSB of a repetition that is not the last, the block SHALL begin the next repetition (or enter GAP, see Configuration) without an idle cycle.
REQ-016 After the LSB of the last repetition, the block SHALL enter DONE; done=1, valid=0, out=0 for exactly one cycle, then IDLE.
REQ-017 Without a gap, a transfer SHALL occupy exactly repeat_cnt*PAT_W consecutive valid cycles.
REQ-018 When valid=0, out SHALL be 0.
REQ-019 start SHALL be ignored while busy=1; start held high through DONE SHALL launch a new transfer from IDLE on the following edge.
REQ-020 abort=1 in SEND or GAP SHALL force IDLE on the next edge with out=0, valid=0, busy=0 and no done pulse; abort in IDLE or DONE SHALL have no effect.
REQ-021 If abort and start are both high in IDLE, start SHALL win.
REQ-022 The internal bit index and repetition counter SHALL wrap without overflow for repeat_cnt=15 and PAT_W=16.

Reset
REQ-023 reset=1 at an edge SHALL force IDLE and out=0, valid=0, busy=0, done=0, and clear the latched pattern and counters, overriding start and abort.
REQ-024 Reset asserted mid-transfer SHALL abandon the transfer; no done pulse SHALL follow.

Configuration
REQ-025 With macro SEQ_GEN_GAP_EN defined, the block SHALL insert one GAP cycle (valid=0, out=0, busy=1) between consecutive repetitions, but not after the last one; the transfer length SHALL be repeat_cnt*PAT_W + repeat_cnt-1 cycles.
REQ-026 Without SEQ_GEN_GAP_EN, the GAP state SHALL NOT be reachable and repetitions SHALL be back-to-back.

Verification
REQ-027 pattern=1011, repeat_cnt=1, start pulse: out=1,0,1,1 with valid high for 4 cycles starting 1 cycle after start, done in the 5th cycle, busy low in the 6th.
REQ-028 pattern=1011, repeat_cnt=2: out=10111011 over 8 valid cycles (no gap); with SEQ_GEN_GAP_EN: 1011,gap,1011 over 9 cycles, valid=0 in cycle 5.
REQ-029 repeat_cnt=0, start pulse: valid never high, done high 1 cycle after start.
REQ-030 start re-pulsed and pattern changed to 0000 mid-transfer: the original 1011 stream is unaffected and exactly one done pulse occurs.
REQ-031 abort at the 3rd bit and, separately, reset at the 3rd bit: out/valid/busy are 0 on the next cycle, no done pulse, and a following start works normally.
REQ-032 Loopback: out drives in of sequence_detector with pattern=1011, repeat_cnt=3, no gap; the detector out pulses once per completed 1011 (3 pulses).

Source files
------------

// File: rtl/sequence_generator.sv
// Serial pattern generator: shifts a latched pattern out MSB first, repeat_cnt times.
// Define SEQ_GEN_GAP_EN to insert one idle GAP cycle between consecutive repetitions.
module sequence_generator #(
    parameter int unsigned PAT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [3:0]       repeat_cnt,
    output logic             out,
    output logic             valid,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        GAP,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [3:0]       rep_q, rep_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // idx_q is the position of the bit currently on out; rep_q counts repetitions still owed, including the current one.
    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        idx_d   = idx_q;
        rep_d   = rep_q;
        out_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    pat_d = pattern;
                    rep_d = repeat_cnt;
                    idx_d = IDX_MSB;
                    if (repeat_cnt == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d = SEND;
                        out_d   = pattern[PAT_W-1];
                    end
                end
            end
            SEND: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - 1'b1;
                    out_d = pat_q[idx_d];
                end else if (rep_q > 4'd1) begin
                    rep_d = rep_q - 1'b1;
                    idx_d = IDX_MSB;
`ifdef SEQ_GEN_GAP_EN
                    state_d = GAP;
`else
                    out_d   = pat_q[PAT_W-1];
`endif
                end else begin
                    state_d = DONE;
                end
            end
            GAP: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    state_d = SEND;
                    out_d   = pat_q[PAT_W-1];
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        valid_d = (state_d == SEND);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pat_q   <= '0;
            idx_q   <= '0;
            rep_q   <= '0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            idx_q   <= idx_d;
            rep_q   <= rep_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out   = out_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_sequence_generator.sv
// Bench for sequence_generator: per-transfer expected-trace model plus directed literal checks.
// Honours SEQ_GEN_GAP_EN when defined for both the DUT and the model.
module tb_sequence_generator;

    localparam int unsigned PAT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             abort;
    logic [PAT_W-1:0] pattern;
    logic [3:0]       repeat_cnt;
    logic             out;
    logic             valid;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    sequence_generator #(.PAT_W(PAT_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .out        (out),
        .valid      (valid),
        .busy       (busy),
        .done       (done)
    );

    typedef struct packed {
        logic out;
        logic valid;
        logic busy;
        logic done;
    } exp_t;

    exp_t mq[$];
    exp_t cur = '0;

    int checks = 0;
    int errors = 0;

    logic        s_out, s_valid, s_busy, s_done;
    logic [63:0] bit_log;
    int          nbits, ndone, nbusy, det;
    logic [3:0]  sh;

    // A transfer is a fixed list of output cycles: bits MSB first per repetition, optional gaps, one done cycle.
    function automatic void build(input logic [PAT_W-1:0] pat, input logic [3:0] n);
        for (int r = 0; r < int'(n); r++) begin
            for (int b = PAT_W - 1; b >= 0; b--)
                mq.push_back(exp_t'{pat[b], 1'b1, 1'b1, 1'b0});
`ifdef SEQ_GEN_GAP_EN
            if (r < int'(n) - 1)
                mq.push_back(exp_t'{1'b0, 1'b0, 1'b1, 1'b0});
`endif
        end
        mq.push_back(exp_t'{1'b0, 1'b0, 1'b1, 1'b1});
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            cur <= '0;
        end else if (!cur.busy) begin
            if (start) begin
                build(pattern, repeat_cnt);
                cur <= mq.pop_front();
            end else begin
                cur <= '0;
            end
        end else if (abort && !cur.done) begin
            mq.delete();
            cur <= '0;
        end else if (mq.size() > 0) begin
            cur <= mq.pop_front();
        end else begin
            cur <= '0;
        end
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h at %0t", nm, a, e, $time);
        end
    endtask

    // Sample and compare mid-cycle, then step to just after the next rising edge.
    task automatic cyc();
        @(negedge clk);
        s_out   = out;
        s_valid = valid;
        s_busy  = busy;
        s_done  = done;
        chk("cycle_out_valid_busy_done", {s_out, s_valid, s_busy, s_done}, cur);
        if (s_valid) begin
            bit_log = {bit_log[62:0], s_out};
            nbits++;
        end
        if (s_done) ndone++;
        if (s_busy) nbusy++;
        sh = {sh[2:0], s_out};
        if (sh == 4'b1011) det++;
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        bit_log = '0;
        nbits   = 0;
        ndone   = 0;
        nbusy   = 0;
        det     = 0;
        sh      = '0;
    endtask

    function automatic logic [63:0] last(input int k);
        return bit_log & ((64'd1 << k) - 64'd1);
    endfunction

    task automatic launch(input logic [PAT_W-1:0] pat, input logic [3:0] n);
        pattern    = pat;
        repeat_cnt = n;
        start      = 1'b1;
        cyc();
        start      = 1'b0;
    endtask

    initial begin
        logic [3:0] e;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = '0;
        repeat_cnt = '0;
        clr();
        @(posedge clk);
        #1;
        start = 1'b1;
        abort = 1'b1;
        cyc();
        cyc();
        chk("reset_state", {s_out, s_valid, s_busy, s_done}, 4'b0000);
        start = 1'b0;
        abort = 1'b0;
        reset = 1'b0;
        cyc();

        // Single repetition with cycle-exact literal timing.
        clr();
        e = 4'b1011;
        launch(e, 4'd1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            chk("t1_bit", {s_valid, s_out}, {1'b1, e[3-i]});
        end
        cyc();
        chk("t1_done", {s_done, s_valid, s_out, s_busy}, 4'b1001);
        cyc();
        chk("t1_idle", s_busy, 1'b0);

        // Two repetitions.
        clr();
        launch(4'b1011, 4'd2);
        repeat (12) cyc();
        chk("t2_nbits", nbits, 8);
        chk("t2_stream", last(8), 64'hBB);
`ifdef SEQ_GEN_GAP_EN
        chk("t2_busy_cycles", nbusy, 10);
`else
        chk("t2_busy_cycles", nbusy, 9);
`endif
        chk("t2_ndone", ndone, 1);

        // Zero repetitions.
        clr();
        launch(4'b1011, 4'd0);
        cyc();
        chk("t3_done_next", {s_done, s_valid}, 2'b10);
        repeat (3) cyc();
        chk("t3_nbits", nbits, 0);
        chk("t3_ndone", ndone, 1);

        // Re-pulse start and change pattern mid-transfer.
        clr();
        launch(4'b1011, 4'd1);
        cyc();
        pattern = 4'b0000;
        start   = 1'b1;
        cyc();
        start   = 1'b0;
        repeat (6) cyc();
        chk("t4_stream", last(4), 64'hB);
        chk("t4_nbits", nbits, 4);
        chk("t4_ndone", ndone, 1);

        // Abort on the third bit, then a normal transfer.
        clr();
        launch(4'b1011, 4'd2);
        cyc();
        cyc();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        cyc();
        chk("t5_abort_next", {s_out, s_valid, s_busy, s_done}, 4'b0000);
        repeat (3) cyc();
        chk("t5_nbits", nbits, 3);
        chk("t5_stream", last(3), 64'h5);
        chk("t5_ndone", ndone, 0);
        clr();
        launch(4'b1011, 4'd1);
        repeat (7) cyc();
        chk("t5_after_stream", last(4), 64'hB);
        chk("t5_after_ndone", ndone, 1);

        // Reset on the third bit, then a normal transfer.
        clr();
        launch(4'b1011, 4'd2);
        cyc();
        cyc();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        cyc();
        chk("t6_reset_next", {s_out, s_valid, s_busy, s_done}, 4'b0000);
        repeat (3) cyc();
        chk("t6_ndone", ndone, 0);
        clr();
        launch(4'b0110, 4'd1);
        repeat (7) cyc();
        chk("t6_after_stream", last(4), 64'h6);
        chk("t6_after_ndone", ndone, 1);

        // Start held high through DONE relaunches from IDLE.
        clr();
        pattern    = 4'b1011;
        repeat_cnt = 4'd1;
        start      = 1'b1;
        repeat (7) cyc();
        start = 1'b0;
        repeat (8) cyc();
        chk("t7_ndone", ndone, 2);
        chk("t7_stream", last(8), 64'hBB);

        // Start and abort together in IDLE: start wins.
        clr();
        abort = 1'b1;
        launch(4'b1001, 4'd1);
        abort = 1'b0;
        repeat (7) cyc();
        chk("t8_nbits", nbits, 4);
        chk("t8_stream", last(4), 64'h9);
        chk("t8_ndone", ndone, 1);

        // Loopback into a 1011 detector, three repetitions.
        clr();
        launch(4'b1011, 4'd3);
        repeat (16) cyc();
        chk("t9_detect", det, 3);
        chk("t9_nbits", nbits, 12);

        // Maximum repetition count.
        clr();
        launch(4'b1011, 4'd15);
        repeat (80) cyc();
        chk("t10_nbits", nbits, 60);
        chk("t10_ndone", ndone, 1);
`ifdef SEQ_GEN_GAP_EN
        chk("t10_busy_cycles", nbusy, 75);
`else
        chk("t10_busy_cycles", nbusy, 61);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
